// File: rtl/f_pc_sequencer.sv
// rtl/f_pc_sequencer.sv - F-stage PC register, fetch handshake and redirect sequencing
// Branch targets seen before the delay slot is accepted are parked in PEND until it issues.
module f_pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_BASE    = 32'h0000_3000,
   parameter logic [31:0] IM_TOP     = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [31:0] F_pc,
   output logic        fetch_fire,
   output logic        F_adel,
   output logic        redirect_pending
);

   typedef enum logic {SEQ, PEND} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        accept;

   // A faulting PC never reaches memory; it advances on its own so D gets an AdEL bubble.
   assign F_adel           = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q > IM_TOP);
   assign imem_req         = !stall & !F_adel;
   assign accept           = !stall & (imem_ready | F_adel);
   assign fetch_fire       = accept;
   assign redirect_pending = (state_q == PEND);
   assign F_pc             = pc_q;

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      tgt_d   = tgt_q;
      if (exc_req) begin
         pc_d    = HANDLER_PC;
         state_d = SEQ;
      end else if (eret) begin
         pc_d    = epc;
         state_d = SEQ;
      end else if (state_q == SEQ) begin
         if (br_taken && !stall) begin
            if (accept) begin
               pc_d = br_target;
            end else begin
               tgt_d   = br_target;
               state_d = PEND;
            end
         end else if (accept) begin
            pc_d = pc_q + 32'd4;
         end
      end else if (accept) begin
         // Delay slot has just issued; the parked target becomes the next fetch.
         pc_d    = tgt_q;
         state_d = SEQ;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         state_q <= SEQ;
         tgt_q   <= 32'h0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

endmodule

// File: tb/tb_f_pc_sequencer.sv
// tb/tb_f_pc_sequencer.sv - self-checking bench for f_pc_sequencer
// Directed plan checks with literal values, then randomized traffic against a behavioural model.
module tb_f_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset, stall, exc_req, eret, br_taken, imem_ready;
   logic [31:0] epc, br_target;
   logic        imem_req, fetch_fire, F_adel, redirect_pending;
   logic [31:0] F_pc;

   int total = 0;
   int bad   = 0;

   // Model state: fetch PC, whether a branch target is parked, and that target.
   logic [31:0] m_pc, m_tgt;
   logic        m_pend;
   logic        m_valid = 1'b0;

   always #5 clk = ~clk;

   f_pc_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .eret(eret),
      .epc(epc), .br_taken(br_taken), .br_target(br_target), .imem_ready(imem_ready),
      .imem_req(imem_req), .F_pc(F_pc), .fetch_fire(fetch_fire), .F_adel(F_adel),
      .redirect_pending(redirect_pending)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic m_adel(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
   endfunction

   task automatic drive(input logic r, input logic st, input logic ex, input logic er,
                        input logic [31:0] e, input logic br, input logic [31:0] bt,
                        input logic rdy);
      reset = r; stall = st; exc_req = ex; eret = er; epc = e;
      br_taken = br; br_target = bt; imem_ready = rdy;
      #1;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
   endtask

   // Compare all outputs against the model, then advance both by one clock.
   task automatic tick();
      logic        adel, acc;
      logic [31:0] n_pc, n_tgt;
      logic        n_pend;
      adel = m_adel(m_pc);
      acc  = !stall && (imem_ready || adel);
      if (m_valid) begin
         chk("F_pc", F_pc, m_pc);
         chk("F_adel", {31'b0, F_adel}, {31'b0, adel});
         chk("imem_req", {31'b0, imem_req}, {31'b0, !stall && !adel});
         chk("fetch_fire", {31'b0, fetch_fire}, {31'b0, acc});
         chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
      end
      n_pc = m_pc; n_tgt = m_tgt; n_pend = m_pend;
      if (reset) begin
         n_pc = 32'h3000; n_pend = 1'b0; n_tgt = 32'h0;
      end else if (exc_req) begin
         n_pc = 32'h4180; n_pend = 1'b0;
      end else if (eret) begin
         n_pc = epc; n_pend = 1'b0;
      end else if (!m_pend && br_taken && !stall) begin
         if (acc) n_pc = br_target;
         else begin n_pend = 1'b1; n_tgt = br_target; end
      end else if (m_pend) begin
         if (acc) begin n_pc = m_tgt; n_pend = 1'b0; end
      end else if (acc) begin
         n_pc = m_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_tgt = n_tgt; m_pend = n_pend;
      if (reset) m_valid = 1'b1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
   endtask

   initial begin
      idle(1'b1);
      @(posedge clk); #1;

      // Reset state and sequential fetch.
      do_reset();
      idle(1'b1);
      chk("rst_pc", F_pc, 32'h3000);
      chk("rst_req", {31'b0, imem_req}, 32'h1);
      chk("rst_pend", {31'b0, redirect_pending}, 32'h0);
      tick(); chk("seq1", F_pc, 32'h3004);
      tick(); chk("seq2", F_pc, 32'h3008);
      tick(); chk("seq3", F_pc, 32'h300C);

      // Branch with delay slot accepted immediately.
      do_reset(); idle(1'b1); tick(); tick();
      chk("br_at", F_pc, 32'h3008);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3100, 1'b1);
      tick();
      chk("br_now_pc", F_pc, 32'h3100);
      chk("br_now_pend", {31'b0, redirect_pending}, 32'h0);

      // Branch while memory not ready: parks in PEND.
      do_reset(); idle(1'b1); tick(); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3100, 1'b0);
      tick();
      chk("pend1", {31'b0, redirect_pending}, 32'h1);
      chk("pend1_pc", F_pc, 32'h3008);
      idle(1'b0); tick();
      chk("pend2", {31'b0, redirect_pending}, 32'h1);
      chk("pend2_pc", F_pc, 32'h3008);
      idle(1'b1); tick();
      chk("pend_done_pc", F_pc, 32'h3100);
      chk("pend_done", {31'b0, redirect_pending}, 32'h0);

      // Exception while pending drops the target.
      do_reset(); idle(1'b1); tick(); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3100, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
      chk("exc_pc", F_pc, 32'h4180);
      chk("exc_pend", {31'b0, redirect_pending}, 32'h0);
      idle(1'b1); tick();
      chk("exc_seq", F_pc, 32'h4184);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h3020, 1'b0, 32'h0, 1'b1);
      tick();
      chk("exc_over_eret", F_pc, 32'h4180);

      // Stall swallows branch; eret still redirects under stall.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3100, 1'b1);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
      chk("stall_fire", {31'b0, fetch_fire}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", F_pc, 32'h4180);
         chk("stall_pend", {31'b0, redirect_pending}, 32'h0);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h3020, 1'b0, 32'h0, 1'b1);
      tick();
      chk("eret_stall", F_pc, 32'h3020);

      // Misaligned eret target: AdEL, no memory request, advances anyway.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3002, 1'b0, 32'h0, 1'b1);
      tick();
      idle(1'b0);
      chk("adel", {31'b0, F_adel}, 32'h1);
      chk("adel_req", {31'b0, imem_req}, 32'h0);
      chk("adel_fire", {31'b0, fetch_fire}, 32'h1);
      tick();
      chk("adel_next", F_pc, 32'h3006);

      // Reset while pending.
      do_reset(); idle(1'b1); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3200, 1'b0);
      tick();
      chk("pre_rst_pend", {31'b0, redirect_pending}, 32'h1);
      do_reset();
      chk("rst_pend_pc", F_pc, 32'h3000);
      chk("rst_pend_clr", {31'b0, redirect_pending}, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] e, t;
         e = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
         case ($urandom_range(0, 7))
            0: e = e + 32'd2;
            1: e = 32'h6FF0 + ($urandom_range(0, 7) << 2);
            2: e = 32'h2FF8;
            default: ;
         endcase
         t = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 15) == 0), e,
               ($urandom_range(0, 3) == 0), t, ($urandom_range(0, 1) == 1));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/f_pc_sequencer.md
Name: f_pc_sequencer

Overview:
- Owns the F-stage PC register and sequences every PC change: sequential, branch/jump redirect from D, exception entry, `eret` return.
- Manages the instruction-memory fetch handshake.
- Holds a branch target when the delay-slot fetch has not yet been accepted, and applies it once that fetch issues.
- Flags fetch address errors for CP0.
- Sits between the D-stage next-PC logic, CP0 and the instruction memory port.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  F/D hold from hazard unit; F_pc must not advance.
- exc_req  in  1  CP0 exception taken this cycle.
- eret  in  1  eret in D, redirect to epc.
- epc  in  32  CP0 EPC value.
- br_taken  in  1  D-stage control transfer resolved taken (jump, jr, taken branch).
- br_target  in  32  target for br_taken.
- imem_ready  in  1  instruction memory accepts request this cycle.
- imem_req  out  1  fetch request for address F_pc.
- F_pc  out  32  current fetch PC.
- fetch_fire  out  1  F instruction advances to D this cycle.
- F_adel  out  1  fetch address error for F_pc.
- redirect_pending  out  1  branch target buffered (state PEND).

Behaviour:
- Reset (synchronous, highest priority, overrides everything):
  - F_pc = RESET_PC, state = SEQ, pend_target = 0.
  - Outputs follow combinationally from this state.
- F_adel (combinational) = (F_pc[1:0] != 0) | (F_pc < IM_BASE) | (F_pc > IM_TOP), unsigned compare.
- imem_req = !stall & !F_adel.
- accept = !stall & (imem_ready | F_adel).
  - A faulting PC advances without touching memory; D receives a bubble tagged AdEL.
- fetch_fire = accept.
- redirect_pending = (state == PEND).
- Next-state priority each cycle, highest first:
  1. exc_req: F_pc <= HANDLER_PC, state <= SEQ, pending dropped. Ignores stall and accept.
  2. eret: F_pc <= epc, state <= SEQ, pending dropped. Ignores stall.
  3. br_taken & !stall, state SEQ:
     - If accept (delay slot issuing now): F_pc <= br_target, stay SEQ.
     - Else: pend_target <= br_target, state <= PEND, F_pc held.
  4. state PEND:
     - On accept (delay slot issued): F_pc <= pend_target, state <= SEQ.
     - Else hold.
     - br_taken in PEND is ignored: a delay-slot instruction cannot be in D.
  5. state SEQ, accept: F_pc <= F_pc + 4 (32-bit wrap, no carry-out).
  6. Otherwise hold F_pc.
- br_taken while stall=1 is ignored: D holds and re-presents it next cycle.
- exc_req and eret both high: exc_req wins.
- exc_req during PEND: target discarded, next fetch is HANDLER_PC.
- imem_ready low for N cycles: F_pc, state and pend_target stable for all N cycles; imem_req stays high unless stall.
- Latency: a redirect takes effect on F_pc the cycle after it is sampled. No combinational path from exc_req/eret/br_* to F_pc.
- Only two states (SEQ, PEND); the PEND→PEND self-loop is the only wait state.

Test Plan:
- Reset → F_pc=0x3000, imem_req=1, redirect_pending=0. With imem_ready=1 for 3 cycles → F_pc 0x3004, 0x3008, 0x300C.
- At F_pc=0x3008, br_taken=1, br_target=0x3100, imem_ready=1 → next F_pc=0x3100, no PEND.
- At F_pc=0x3008, br_taken=1, br_target=0x3100, imem_ready=0 for 2 cycles then 1:
  - redirect_pending=1 and F_pc=0x3008 for 2 cycles.
  - Then F_pc=0x3100, pending=0.
- In PEND (target 0x3100), exc_req=1 → F_pc=0x4180, pending=0, target discarded. Separately, exc_req=1 and eret=1 (epc=0x3020) together → F_pc=0x4180.
- stall=1 for 3 cycles with br_taken=1 → imem_req=0, fetch_fire=0, F_pc unchanged, no PEND. eret=1, epc=0x3020 with stall=1 → F_pc=0x3020 next cycle.
- eret to epc=0x3002 → F_adel=1, imem_req=0, fetch_fire=1, next F_pc=0x3006. Separately, reset asserted while in PEND → F_pc=0x3000, pending=0.
